// File: rtl/result_tx_pkg.sv
// Shared definitions for the result_tx serial transmitter: FSM encoding and
// the helper that sizes its counters.
package result_tx_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  // Bits needed to hold 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = (n <= 1) ? 1 : $clog2(n);
    return w;
  endfunction

endpackage

// File: rtl/result_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, held at zero
// otherwise, and flags the last cycle of each bit period.
module bit_timer
  import result_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_tick
);

  localparam int unsigned CntW = cnt_width(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (i_enable && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = i_enable && (cnt_q == LastCnt);

endmodule

// File: rtl/result_tx.sv
// Serialises an ALU result word as an 8N1-style UART frame (start, data LSB
// first, one or two stop bits) with a valid/ready request handshake.
module result_tx
  import result_tx_pkg::*;
#(
  parameter int unsigned N_BITS       = 8,
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [N_BITS-1:0] i_data,
  output logic              o_ready,
  output logic              o_tx,
  output logic              o_done
);

  localparam int unsigned IdxW = cnt_width(N_BITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_BITS - 1);
  localparam logic LastStop = (STOP_BITS == 2);

  tx_state_e         state_q, state_d;
  logic [N_BITS-1:0] shift_q, shift_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              stop_q, stop_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              tick;
  logic              accept;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_enable(state_q != StIdle),
    .o_tick  (tick)
  );

  assign accept = i_valid && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StStart;
          shift_d = i_data;
          idx_d   = '0;
          stop_d  = 1'b0;
        end
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
        end
      end
      StData: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == LastIdx) begin
            state_d = StStop;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (stop_q == LastStop) begin
            state_d = StIdle;
            stop_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level is derived from the next state so o_tx stays a pure register.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign o_ready = (state_q == StIdle);
  assign o_tx    = tx_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_result_tx.sv
// Directed bench for result_tx with CLKS_PER_BIT=4, N_BITS=8, STOP_BITS=1.
module tb_result_tx;

  localparam int unsigned Clks = 4;

  logic       clk;
  logic       i_reset;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic       o_tx;
  logic       o_done;

  int checks   = 0;
  int failures = 0;

  result_tx #(
    .N_BITS      (8),
    .CLKS_PER_BIT(Clks),
    .STOP_BITS   (1)
  ) dut (
    .i_clock(clk),
    .i_reset(i_reset),
    .i_valid(i_valid),
    .i_data (i_data),
    .o_ready(o_ready),
    .o_tx   (o_tx),
    .o_done (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of the first start-bit cycle; returns at the negedge
  // of the cycle after the last stop bit. mode 1: busy request, mode 2: change data.
  task automatic frame_body(input logic [7:0] d, input string tag, input int mode);
    logic exp;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < int'(Clks); c++) begin
        int k;
        k = b * int'(Clks) + c;
        if (mode == 1 && k == 12) begin
          i_valid = 1'b1;
          i_data  = 8'hFF;
        end
        if (mode == 1 && k == 24) i_valid = 1'b0;
        if (mode == 2 && k == 0) i_data = 8'h7E;
        if (b == 0) exp = 1'b0;
        else if (b == 9) exp = 1'b1;
        else exp = d[b-1];
        chk($sformatf("%s_tx_b%0d_c%0d", tag, b, c), {7'd0, o_tx}, {7'd0, exp});
        chk($sformatf("%s_ready_k%0d", tag, k), {7'd0, o_ready}, 8'd0);
        chk($sformatf("%s_done_k%0d", tag, k), {7'd0, o_done}, 8'd0);
        @(negedge clk);
      end
    end
  endtask

  task automatic chk_done_cycle(input string tag);
    chk({tag, "_done"}, {7'd0, o_done}, 8'd1);
    chk({tag, "_done_ready"}, {7'd0, o_ready}, 8'd1);
    chk({tag, "_done_tx"}, {7'd0, o_tx}, 8'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_idle_done"}, {7'd0, o_done}, 8'd0);
    chk({tag, "_idle_ready"}, {7'd0, o_ready}, 8'd1);
    chk({tag, "_idle_tx"}, {7'd0, o_tx}, 8'd1);
  endtask

  initial begin
    i_reset = 1'b1;
    i_valid = 1'b1;
    i_data  = 8'h55;
    // Reset wins over a simultaneous request.
    repeat (2) @(negedge clk);
    chk_idle("reset");
    i_reset = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    // Single frame 0xA5
    i_data  = 8'hA5;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    frame_body(8'hA5, "single", 0);
    chk_done_cycle("single");
    @(negedge clk);
    chk_idle("single");

    // Request while busy is dropped
    i_data  = 8'hA5;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    frame_body(8'hA5, "busy", 1);
    chk_done_cycle("busy");
    @(negedge clk);
    chk_idle("busy");

    // Back-to-back with i_valid held high
    i_data  = 8'h00;
    i_valid = 1'b1;
    @(negedge clk);
    frame_body(8'h00, "b2b0", 0);
    chk_done_cycle("b2b0");
    i_data = 8'hFF;
    @(negedge clk);
    i_valid = 1'b0;
    frame_body(8'hFF, "b2b1", 0);
    chk_done_cycle("b2b1");
    @(negedge clk);
    chk_idle("b2b1");

    // Reset during data bit 3 abandons the frame
    i_data  = 8'hA5;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    for (int k = 0; k < 17; k++) begin
      logic exp;
      if (k < 4) exp = 1'b0;
      else exp = i_data[(k-4)/4];
      chk($sformatf("rst_pre_tx_k%0d", k), {7'd0, o_tx}, {7'd0, exp});
      @(negedge clk);
    end
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    chk_idle("rst_mid");
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      chk($sformatf("rst_quiet_done_k%0d", k), {7'd0, o_done}, 8'd0);
      chk($sformatf("rst_quiet_tx_k%0d", k), {7'd0, o_tx}, 8'd1);
    end
    i_data  = 8'h3C;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    frame_body(8'h3C, "after_rst", 0);
    chk_done_cycle("after_rst");
    @(negedge clk);
    chk_idle("after_rst");

    // Data change after accept does not reach the line
    i_data  = 8'h81;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    frame_body(8'h81, "stable", 2);
    chk_done_cycle("stable");
    @(negedge clk);
    chk_idle("stable");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
